memory_latency_injector_contention: RTL and testbench
=====================================================

MEMORY_LATENCY_INJECTOR_CONTENTION -- requirements
Module: memory_latency_injector_contention

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 8: in-flight request entries.
REQ-002 SHALL have parameter EXTRA_LATENCY_MAX, default 4: maximum random extra latency, in cycles.
REQ-003 SHALL have parameter LATENCY_DIST_MODE, default 0: 0 = no extra latency, 1 = uniform extra latency, 2 = fixed extra latency of EXTRA_LATENCY_MAX.
REQ-004 SHALL have parameters SRAM_LATENCY, default 2, and DRAM_LATENCY, default 40: built-in latencies.
REQ-005 Ports, all 1-bit unless a width is given:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_is_dram  in  1  1 = DRAM target, 0 = SRAM target.
- req_size_bytes  in  16  request size.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- resp_valid  out  1  one-cycle completion pulse.
- resp_size_bytes  out  16  size of the completing request.
- cfg_latency_sram, cfg_latency_dram  in  16  configured latencies.
- cfg_dram_hit_milli_pct  in  10  DRAM hit rate in per-mille.
- cfg_use_cfg_latencies  in  1  1 = use cfg latencies, 0 = use parameters.
- cfg_enable_contention  in  1  enables the token bucket.
- cfg_tokens_per_cycle  in  8  bucket refill per cycle.
- cfg_token_capacity  in  16  bucket ceiling.
- total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles  out  32  statistics counters.
- busy  out  1  queue non-empty.
- dram_tokens_level  out  16  current bucket level.
- dram_token_stall_cycles, dram_contention_events  out  32  contention counters.

Function
REQ-006 SHALL hold requests in an in-order FIFO of QUEUE_DEPTH entries; each entry stores its size and a remaining-latency down-counter.
REQ-007 SHALL drive req_ready = !full && token_ok, combinationally from the current state; the queue has no bypass path when full.
REQ-008 On accept, latency SHALL equal base + extra, clamped to a minimum of 1, so resp_valid occurs no earlier than the cycle after accept.
REQ-009 Base latency SHALL be: SRAM latency for SRAM requests; for DRAM requests, SRAM latency on a hit, DRAM latency otherwise. Latency values come from cfg_* or the parameters per cfg_use_cfg_latencies.
REQ-010 A DRAM request SHALL hit when lfsr[9:0] < cfg_dram_hit_milli_pct; a value of 1000 or more SHALL always hit.
REQ-011 In mode 1, extra latency SHALL be lfsr[15:10] mod (EXTRA_LATENCY_MAX+1).
REQ-012 The 16-bit Galois LFSR (taps 0xB400) SHALL be seeded with 0xACE1 and advance every cycle.
REQ-013 All entry counters SHALL decrement each cycle, saturating at 0.
REQ-014 When the head counter is 0, the head SHALL pop with resp_valid=1 and resp_size_bytes equal to the head size; at most one pop per cycle, in order (head-of-line blocking is intended).
REQ-015 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-016 Counter updates:
- total_reqs increments per accept.
- sram_reqs and dram_reqs increment per accept by target.
- total_resp increments per resp_valid.
- stall_cycles increments per cycle with req_valid && !req_ready.
- busy_cycles increments per cycle with busy=1.
- All counters wrap at 2^32.
REQ-017 Token cost SHALL be max(1, ceil(size/4)), clamped to cfg_token_capacity.
REQ-018 token_ok SHALL be 1 for SRAM requests, or when contention is disabled; otherwise level >= cost.
REQ-019 Each cycle, level SHALL become min(level - consumed + cfg_tokens_per_cycle, cfg_token_capacity).
REQ-020 dram_token_stall_cycles SHALL increment per cycle in which a DRAM req_valid is blocked only by tokens.
REQ-021 dram_contention_events SHALL increment on the first cycle of each such stall run.

Reset
REQ-022 Reset SHALL clear the queue, every counter, resp_valid, resp_size_bytes and busy.
REQ-023 Reset SHALL load the LFSR with its seed and dram_tokens_level with cfg_token_capacity.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries with no responses.

Configuration
REQ-025 The token bucket SHALL be compiled only when macro MLIC_TOKEN_BUCKET_EN is defined.
REQ-026 Without MLIC_TOKEN_BUCKET_EN:
- token_ok is constantly 1.
- dram_tokens_level, dram_token_stall_cycles and dram_contention_events are tied to 0.
- cfg_enable_contention, cfg_tokens_per_cycle and cfg_token_capacity are ignored.

Structure
REQ-027 Package mlic_pkg SHALL hold LFSR seed and taps, the hit-forced threshold 1000, the token cost shift of 2, and the entry struct (size, counter).
REQ-028 A sub-module mlic_token_bucket SHALL implement the bucket logic of REQ-017 to REQ-021.

Verification
REQ-029 SRAM only, cfg latency 2, mode 0, one request of 64 B: resp_valid SHALL pulse exactly 2 cycles after accept with size 64.
REQ-030 DRAM, pct=0, latency 20, mode 0: response SHALL come at 20 cycles; with pct=1000 it SHALL come at 2 cycles.
REQ-031 Hold req_valid for 9 back-to-back SRAM requests with latency 50, QUEUE_DEPTH 8: req_ready SHALL drop after 8 accepts and stall_cycles SHALL increment.
REQ-032 Contention on, capacity 64, 8 tokens/cycle, continuous 128 B DRAM requests (cost 32): level SHALL stay at or below 64, and dram_token_stall_cycles and dram_contention_events SHALL both be > 0.
REQ-033 Random two-source DRAM load for 2000 cycles: total_resp SHALL stay <= total_reqs, and total_reqs SHALL equal sram_reqs + dram_reqs.
REQ-034 Reset with 3 entries in flight: no resp_valid SHALL occur afterwards, and all counters SHALL read 0.

Source files
------------

// File: rtl/mlic_pkg.sv
// Shared constants, entry payload and LFSR step for the memory latency injector.
package mlic_pkg;

    localparam int unsigned SIZE_W  = 16;
    localparam int unsigned LAT_W   = 24;
    localparam int unsigned STAT_W  = 32;
    localparam int unsigned LEVEL_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Per-mille values at or above this always hit.
    localparam logic [9:0] HIT_FORCE_PCT = 10'd1000;

    // One token per 4 bytes.
    localparam int unsigned TOKEN_COST_SHIFT = 2;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [LAT_W-1:0]  cnt;
    } entry_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/mlic_token_bucket.sv
// DRAM bandwidth token bucket; real logic only when MLIC_TOKEN_BUCKET_EN is defined,
// otherwise it always grants and reports zero level and zero stall counts.
module mlic_token_bucket
    import mlic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_is_dram,
    input  logic [SIZE_W-1:0]  req_size_bytes,
    input  logic               full,
    input  logic               accept,
    input  logic               enable_contention,
    input  logic [7:0]         tokens_per_cycle,
    input  logic [LEVEL_W-1:0] token_capacity,
    output logic               token_ok_c,
    output logic [LEVEL_W-1:0] level,
    output logic [STAT_W-1:0]  stall_cycles,
    output logic [STAT_W-1:0]  contention_events
);

`ifdef MLIC_TOKEN_BUCKET_EN
    logic [LEVEL_W-1:0] cost_ceil;
    logic [LEVEL_W-1:0] cost_min1;
    logic [LEVEL_W-1:0] cost;
    logic [LEVEL_W-1:0] consumed;
    logic [LEVEL_W+1:0] refill;
    logic [LEVEL_W-1:0] level_next;
    logic               token_stall;
    logic               token_stall_q;

    // Cost, grant and next level are all derived from the current level.
    always_comb begin
        cost_ceil   = LEVEL_W'((17'(req_size_bytes) + 17'd3) >> TOKEN_COST_SHIFT);
        cost_min1   = (cost_ceil == '0) ? LEVEL_W'(1) : cost_ceil;
        cost        = (cost_min1 > token_capacity) ? token_capacity : cost_min1;
        token_ok_c  = !req_is_dram || !enable_contention || (level >= cost);
        consumed    = (accept && req_is_dram && enable_contention) ? cost : '0;
        refill      = 18'(level) - 18'(consumed) + 18'(tokens_per_cycle);
        level_next  = (refill > 18'(token_capacity)) ? token_capacity : LEVEL_W'(refill);
        token_stall = req_valid && req_is_dram && !full && !token_ok_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level             <= token_capacity;
            stall_cycles      <= '0;
            contention_events <= '0;
            token_stall_q     <= 1'b0;
        end else begin
            level         <= level_next;
            token_stall_q <= token_stall;
            if (token_stall) begin
                stall_cycles <= stall_cycles + STAT_W'(1);
            end
            if (token_stall && !token_stall_q) begin
                contention_events <= contention_events + STAT_W'(1);
            end
        end
    end
`else
    logic unused_bucket_inputs;

    assign unused_bucket_inputs = ^{clk, reset, req_valid, req_is_dram, req_size_bytes, full,
                                    accept, enable_contention, tokens_per_cycle, token_capacity};
    assign token_ok_c        = 1'b1;
    assign level             = '0;
    assign stall_cycles      = '0;
    assign contention_events = '0;
`endif

endmodule

// File: rtl/memory_latency_injector_contention.sv
// In-order latency injector: each accepted request completes after an SRAM/DRAM latency
// plus optional random extra; DRAM bandwidth throttling is enabled by MLIC_TOKEN_BUCKET_EN.
module memory_latency_injector_contention
    import mlic_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH       = 8,
    parameter int unsigned EXTRA_LATENCY_MAX = 4,
    parameter int unsigned LATENCY_DIST_MODE = 0,
    parameter int unsigned SRAM_LATENCY      = 2,
    parameter int unsigned DRAM_LATENCY      = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_is_dram,
    input  logic [SIZE_W-1:0]  req_size_bytes,
    output logic               req_ready,
    output logic               resp_valid,
    output logic [SIZE_W-1:0]  resp_size_bytes,
    input  logic [15:0]        cfg_latency_sram,
    input  logic [15:0]        cfg_latency_dram,
    input  logic [9:0]         cfg_dram_hit_milli_pct,
    input  logic               cfg_use_cfg_latencies,
    input  logic               cfg_enable_contention,
    input  logic [7:0]         cfg_tokens_per_cycle,
    input  logic [LEVEL_W-1:0] cfg_token_capacity,
    output logic [STAT_W-1:0]  total_reqs,
    output logic [STAT_W-1:0]  total_resp,
    output logic [STAT_W-1:0]  sram_reqs,
    output logic [STAT_W-1:0]  dram_reqs,
    output logic [STAT_W-1:0]  stall_cycles,
    output logic [STAT_W-1:0]  busy_cycles,
    output logic               busy,
    output logic [LEVEL_W-1:0] dram_tokens_level,
    output logic [STAT_W-1:0]  dram_token_stall_cycles,
    output logic [STAT_W-1:0]  dram_contention_events
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    entry_t           mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic [15:0]      lfsr;

    logic             full;
    logic             token_ok;
    logic             accept;
    logic             pop;
    logic             dram_hit;
    logic [LAT_W-1:0] sram_lat;
    logic [LAT_W-1:0] dram_lat;
    logic [LAT_W-1:0] base_lat;
    logic [LAT_W-1:0] extra_lat;
    logic [LAT_W-1:0] lat_sum;
    logic [LAT_W-1:0] lat_load;

    assign full      = (occ == OCC_W'(QUEUE_DEPTH));
    assign req_ready = !full && token_ok;
    assign accept    = req_valid && req_ready;
    assign pop       = (occ != '0) && (mem[head].cnt == '0);

    // Stored count is latency-1 so a latency of L pulses resp_valid L cycles after accept.
    always_comb begin
        sram_lat  = cfg_use_cfg_latencies ? LAT_W'(cfg_latency_sram) : LAT_W'(SRAM_LATENCY);
        dram_lat  = cfg_use_cfg_latencies ? LAT_W'(cfg_latency_dram) : LAT_W'(DRAM_LATENCY);
        dram_hit  = (cfg_dram_hit_milli_pct >= HIT_FORCE_PCT) ||
                    (lfsr[9:0] < cfg_dram_hit_milli_pct);
        base_lat  = (req_is_dram && !dram_hit) ? dram_lat : sram_lat;
        extra_lat = '0;
        if (LATENCY_DIST_MODE == 1) begin
            extra_lat = LAT_W'(32'(lfsr[15:10]) % (EXTRA_LATENCY_MAX + 1));
        end else if (LATENCY_DIST_MODE == 2) begin
            extra_lat = LAT_W'(EXTRA_LATENCY_MAX);
        end
        lat_sum  = base_lat + extra_lat;
        lat_load = (lat_sum == '0) ? '0 : lat_sum - LAT_W'(1);
    end

    always_comb begin
        occ_next = occ;
        case ({accept, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage: every counter ages each cycle; the newly pushed slot takes its fresh load.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                if (mem[i].cnt != '0) begin
                    mem[i].cnt <= mem[i].cnt - LAT_W'(1);
                end
            end
            if (accept) begin
                mem[tail] <= '{size: req_size_bytes, cnt: lat_load};
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            occ <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr            <= LFSR_SEED;
            resp_valid      <= 1'b0;
            resp_size_bytes <= '0;
            busy            <= 1'b0;
            total_reqs      <= '0;
            total_resp      <= '0;
            sram_reqs       <= '0;
            dram_reqs       <= '0;
            stall_cycles    <= '0;
            busy_cycles     <= '0;
        end else begin
            lfsr       <= lfsr_next(lfsr);
            resp_valid <= pop;
            busy       <= (occ_next != '0);
            if (pop) begin
                resp_size_bytes <= mem[head].size;
                total_resp      <= total_resp + STAT_W'(1);
            end
            if (accept) begin
                total_reqs <= total_reqs + STAT_W'(1);
                if (req_is_dram) begin
                    dram_reqs <= dram_reqs + STAT_W'(1);
                end else begin
                    sram_reqs <= sram_reqs + STAT_W'(1);
                end
            end
            if (req_valid && !req_ready) begin
                stall_cycles <= stall_cycles + STAT_W'(1);
            end
            if (busy) begin
                busy_cycles <= busy_cycles + STAT_W'(1);
            end
        end
    end

    mlic_token_bucket u_token_bucket (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_is_dram       (req_is_dram),
        .req_size_bytes    (req_size_bytes),
        .full              (full),
        .accept            (accept),
        .enable_contention (cfg_enable_contention),
        .tokens_per_cycle  (cfg_tokens_per_cycle),
        .token_capacity    (cfg_token_capacity),
        .token_ok_c        (token_ok),
        .level             (dram_tokens_level),
        .stall_cycles      (dram_token_stall_cycles),
        .contention_events (dram_contention_events)
    );

endmodule

// File: tb/tb_memory_latency_injector_contention.sv
// Directed bench for the latency injector: scoreboard of expected response size/cycle,
// counter checks, full-queue stall, mid-flight reset, token bucket and a random load.
module tb_memory_latency_injector_contention;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_is_dram = 1'b0;
    logic [15:0] req_size_bytes = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_size_bytes;
    logic [15:0] cfg_latency_sram = 16'd2;
    logic [15:0] cfg_latency_dram = 16'd20;
    logic [9:0]  cfg_dram_hit_milli_pct = '0;
    logic        cfg_use_cfg_latencies = 1'b1;
    logic        cfg_enable_contention = 1'b0;
    logic [7:0]  cfg_tokens_per_cycle = 8'd8;
    logic [15:0] cfg_token_capacity = 16'd64;
    logic [31:0] total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles;
    logic        busy;
    logic [15:0] dram_tokens_level;
    logic [31:0] dram_token_stall_cycles, dram_contention_events;

    memory_latency_injector_contention dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_is_dram             (req_is_dram),
        .req_size_bytes          (req_size_bytes),
        .req_ready               (req_ready),
        .resp_valid              (resp_valid),
        .resp_size_bytes         (resp_size_bytes),
        .cfg_latency_sram        (cfg_latency_sram),
        .cfg_latency_dram        (cfg_latency_dram),
        .cfg_dram_hit_milli_pct  (cfg_dram_hit_milli_pct),
        .cfg_use_cfg_latencies   (cfg_use_cfg_latencies),
        .cfg_enable_contention   (cfg_enable_contention),
        .cfg_tokens_per_cycle    (cfg_tokens_per_cycle),
        .cfg_token_capacity      (cfg_token_capacity),
        .total_reqs              (total_reqs),
        .total_resp              (total_resp),
        .sram_reqs               (sram_reqs),
        .dram_reqs               (dram_reqs),
        .stall_cycles            (stall_cycles),
        .busy_cycles             (busy_cycles),
        .busy                    (busy),
        .dram_tokens_level       (dram_tokens_level),
        .dram_token_stall_cycles (dram_token_stall_cycles),
        .dram_contention_events  (dram_contention_events)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] size;
        int          at;
    } exp_t;

    exp_t sb[$];
    bit   sb_on = 1'b1;
    int   last_exp = -1;
    int   n_acc, n_sram, n_dram, resp_seen, viol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Latency only for the hit rates the directed steps use: 0 (always miss) or 1000 (always hit).
    function automatic int exp_lat(input logic d);
        int   b;
        logic miss;
        miss = d && (cfg_dram_hit_milli_pct < 10'd1000);
        if (cfg_use_cfg_latencies) b = miss ? int'(cfg_latency_dram) : int'(cfg_latency_sram);
        else                       b = miss ? 40 : 2;
        return (b < 1) ? 1 : b;
    endfunction

    // Negedge monitor: responses are popped against the scoreboard, accepts push expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                resp_seen++;
                if (sb_on) begin
                    if (sb.size() == 0) begin
                        chk("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_size", 32'(resp_size_bytes), 32'(e.size));
                        chk("resp_cycle", 32'(cyc), 32'(e.at));
                    end
                end
            end
            if (!sb_on && (total_resp > total_reqs)) viol++;
            if (req_valid && req_ready) begin
                n_acc++;
                if (req_is_dram) n_dram++; else n_sram++;
                if (sb_on) begin
                    exp_t e;
                    int   t;
                    t = cyc + 1 + exp_lat(req_is_dram);
                    if (t <= last_exp) t = last_exp + 1;
                    last_exp = t;
                    e.size = req_size_bytes;
                    e.at   = t;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        step();
        step();
        sb.delete();
        last_exp = -1;
        n_acc = 0; n_sram = 0; n_dram = 0; resp_seen = 0; viol = 0;
        reset = 1'b0;
    endtask

    task automatic send(input logic d, input logic [15:0] s, output bit ok);
        req_valid = 1'b1;
        req_is_dram = d;
        req_size_bytes = s;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic chk_zero_stats(input string tag);
        chk({tag, "_total_reqs"}, total_reqs, 32'd0);
        chk({tag, "_total_resp"}, total_resp, 32'd0);
        chk({tag, "_sram_reqs"}, sram_reqs, 32'd0);
        chk({tag, "_dram_reqs"}, dram_reqs, 32'd0);
        chk({tag, "_stall_cycles"}, stall_cycles, 32'd0);
        chk({tag, "_busy_cycles"}, busy_cycles, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_tok_stall"}, dram_token_stall_cycles, 32'd0);
        chk({tag, "_tok_events"}, dram_contention_events, 32'd0);
    endtask

    initial begin
        bit ok;

        // Reset state
        do_reset();
        chk_zero_stats("rst");
        chk("rst_req_ready", 32'(req_ready), 32'd1);
`ifdef MLIC_TOKEN_BUCKET_EN
        chk("rst_level", 32'(dram_tokens_level), 32'd64);
`else
        chk("rst_level", 32'(dram_tokens_level), 32'd0);
`endif

        // Single SRAM request, latency 2
        send(1'b0, 16'd64, ok);
        chk("sram_accept", 32'(ok), 32'd1);
        drain("sram_drain", 20);
        chk("sram_total_resp", total_resp, 32'd1);
        chk("sram_sram_reqs", sram_reqs, 32'd1);
        chk("sram_dram_reqs", dram_reqs, 32'd0);
        chk("sram_busy_cycles", busy_cycles, 32'd2);

        // DRAM miss at 20, then forced hit at the SRAM latency
        do_reset();
        cfg_dram_hit_milli_pct = 10'd0;
        send(1'b1, 16'd32, ok);
        chk("dram_miss_accept", 32'(ok), 32'd1);
        drain("dram_miss_drain", 40);
        cfg_dram_hit_milli_pct = 10'd1000;
        send(1'b1, 16'd16, ok);
        chk("dram_hit_accept", 32'(ok), 32'd1);
        drain("dram_hit_drain", 20);
        chk("dram_dram_reqs", dram_reqs, 32'd2);

        // Parameter latencies, back to back, with head-of-line ordering
        cfg_use_cfg_latencies = 1'b0;
        cfg_dram_hit_milli_pct = 10'd0;
        send(1'b1, 16'd8, ok);
        send(1'b0, 16'd12, ok);
        drain("param_drain", 100);
        chk("param_total_resp", total_resp, 32'd4);

        // Zero latency clamps to one cycle
        cfg_use_cfg_latencies = 1'b1;
        cfg_latency_sram = 16'd0;
        send(1'b0, 16'd4, ok);
        drain("min_lat_drain", 10);

        // Full queue: 9 back-to-back requests at latency 50
        do_reset();
        cfg_latency_sram = 16'd50;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 16'(100 + i), ok);
            chk("full_fill_accept", 32'(ok), 32'd1);
        end
        #1;
        chk("full_ready_low", 32'(req_ready), 32'd0);
        send(1'b0, 16'd200, ok);
        chk("full_ninth_accept", 32'(ok), 32'd1);
        chk("full_stall_cycles", stall_cycles, 32'(50 - 8 + 1));
        drain("full_drain", 200);
        chk("full_total_resp", total_resp, 32'd9);

        // Reset with three entries in flight
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b0, 16'd8, ok);
        chk("flight_busy", 32'(busy), 32'd1);
        do_reset();
        chk_zero_stats("flight");
        repeat (80) step();
        chk("flight_no_resp", 32'(resp_seen), 32'd0);
        chk("flight_total_resp", total_resp, 32'd0);

        // Token bucket contention: capacity 64, 8/cycle, 128 B DRAM requests cost 32
        cfg_latency_sram = 16'd2;
        cfg_dram_hit_milli_pct = 10'd1000;
        cfg_enable_contention = 1'b1;
        cfg_tokens_per_cycle = 8'd8;
        cfg_token_capacity = 16'd64;
`ifdef MLIC_TOKEN_BUCKET_EN
        begin
            int lvl_m, st_m, ev_m;
            bit prev_m, r_m;
            do_reset();
            lvl_m = 64; st_m = 0; ev_m = 0; prev_m = 1'b0;
            req_valid = 1'b1;
            req_is_dram = 1'b1;
            req_size_bytes = 16'd128;
            for (int i = 0; i < 100; i++) begin
                #1;
                r_m = (lvl_m >= 32);
                chk("tok_ready", 32'(req_ready), 32'(r_m));
                chk("tok_level", 32'(dram_tokens_level), 32'(lvl_m));
                chk("tok_level_cap", 32'(dram_tokens_level <= 16'd64), 32'd1);
                if (!r_m) begin
                    st_m++;
                    if (!prev_m) ev_m++;
                end
                prev_m = !r_m;
                lvl_m = lvl_m - (r_m ? 32 : 0) + 8;
                if (lvl_m > 64) lvl_m = 64;
                step();
            end
            req_valid = 1'b0;
            chk("tok_stall_cycles", dram_token_stall_cycles, 32'(st_m));
            chk("tok_events", dram_contention_events, 32'(ev_m));
            chk("tok_stall_nonzero", 32'(dram_token_stall_cycles > 0), 32'd1);
            chk("tok_events_nonzero", 32'(dram_contention_events > 0), 32'd1);
            drain("tok_drain", 20);
        end
`else
        cfg_token_capacity = 16'd0;
        cfg_tokens_per_cycle = 8'd0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 16'd128, ok);
            chk("notok_accept", 32'(ok), 32'd1);
        end
        drain("notok_drain", 30);
        chk("notok_dram_reqs", dram_reqs, 32'd10);
        chk("notok_level", 32'(dram_tokens_level), 32'd0);
        chk("notok_stall", dram_token_stall_cycles, 32'd0);
        chk("notok_events", dram_contention_events, 32'd0);
        chk("notok_stall_cycles", stall_cycles, 32'd0);
        cfg_token_capacity = 16'd64;
        cfg_tokens_per_cycle = 8'd8;
`endif

        // Random two-source load
        do_reset();
        sb_on = 1'b0;
        cfg_dram_hit_milli_pct = 10'd500;
        cfg_latency_sram = 16'd3;
        cfg_latency_dram = 16'd25;
        for (int i = 0; i < 2000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_is_dram = 1'($urandom_range(0, 1));
            req_size_bytes = 16'($urandom_range(1, 256));
            step();
        end
        req_valid = 1'b0;
        step();
        @(negedge clk);
        #1;
        chk("rand_total_reqs", total_reqs, 32'(n_acc));
        chk("rand_sram_reqs", sram_reqs, 32'(n_sram));
        chk("rand_dram_reqs", dram_reqs, 32'(n_dram));
        chk("rand_sum", total_reqs, sram_reqs + dram_reqs);
        chk("rand_total_resp", total_resp, 32'(resp_seen));
        chk("rand_resp_le_reqs", 32'(viol), 32'd0);
        chk("rand_some_accepts", 32'(n_acc > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
